// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared state and read-tag encodings for the data-RAM arbiter
package dmem_arb_pkg;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_OWN_P = 2'd1;
    localparam logic [1:0] ST_OWN_D = 2'd2;
    localparam logic TAG_P = 1'b0;
    localparam logic TAG_D = 1'b1;
endpackage

// File: rtl/starve_counter.sv
// starve_counter: saturating 4-bit count of consecutive refused requests
module starve_counter #(
    parameter int MAX = 4
) (
    input  logic g_clk,
    input  logic g_clr,
    input  logic inc,
    input  logic clr,
    output logic at_max
);
    localparam logic [3:0] MAX_C = 4'(MAX);
    logic [3:0] cnt;
    always_ff @(posedge g_clk)
        if (!g_clr || clr) cnt <= '0;
        else if (inc && cnt != MAX_C) cnt <= cnt + 4'd1;
    assign at_max = cnt == MAX_C;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: fixed-priority pipeline/DMA arbiter for the single-ported data RAM
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int A_WIDTH    = 8,
    parameter int D_WIDTH    = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic               g_clk,
    input  logic               g_clr,
    input  logic               p_req,
    input  logic               p_we,
    input  logic [A_WIDTH-1:0] p_addr,
    input  logic [D_WIDTH-1:0] p_wdata,
    output logic               p_gnt,
    output logic               p_stall,
    input  logic               d_req,
    input  logic               d_we,
    input  logic               d_lock,
    input  logic [A_WIDTH-1:0] d_addr,
    input  logic [D_WIDTH-1:0] d_wdata,
    output logic               d_gnt,
    output logic               rvalid,
    output logic               rtag,
    output logic [D_WIDTH-1:0] rdata,
    output logic [A_WIDTH-1:0] mem_addr,
    output logic               mem_we,
    output logic               mem_re,
    output logic [D_WIDTH-1:0] mem_wdata,
    input  logic [D_WIDTH-1:0] mem_rdata
);
    logic [1:0] state;
    logic       at_max;

    starve_counter #(.MAX(STARVE_MAX)) u_starve (
        .g_clk (g_clk),
        .g_clr (g_clr),
        .inc   (d_req && !d_gnt),
        .clr   (d_gnt || !d_req),
        .at_max(at_max)
    );

    // A held lock, a saturated starve count, or an idle pipeline all hand the RAM to D
    assign d_gnt   = d_req && ((state == ST_OWN_D && d_lock) || at_max || !p_req);
    assign p_gnt   = p_req && !d_gnt;
    assign p_stall = p_req && !p_gnt;

    assign mem_addr  = d_gnt ? d_addr : p_gnt ? p_addr : '0;
    assign mem_wdata = d_gnt ? d_wdata : p_gnt ? p_wdata : '0;
    assign mem_we    = (d_gnt && d_we) || (p_gnt && p_we);
    assign mem_re    = (d_gnt && !d_we) || (p_gnt && !p_we);
    assign rdata     = mem_rdata;

    always_ff @(posedge g_clk)
        if (!g_clr) begin
            state  <= ST_IDLE;
            rvalid <= 1'b0;
            rtag   <= TAG_P;
        end else begin
            state  <= d_gnt ? ST_OWN_D : p_gnt ? ST_OWN_P : ST_IDLE;
            rvalid <= mem_re;
            rtag   <= d_gnt ? TAG_D : TAG_P;
        end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and random checks of dmem_arbiter against a behavioural model
module tb_dmem_arbiter;
    localparam int SM = 4;

    logic       g_clk = 1'b0;
    logic       g_clr, p_req, p_we, p_gnt, p_stall;
    logic       d_req, d_we, d_lock, d_gnt, rvalid, rtag;
    logic       mem_we, mem_re;
    logic [7:0] p_addr, p_wdata, d_addr, d_wdata, rdata, mem_addr, mem_wdata, mem_rdata;

    dmem_arbiter #(.A_WIDTH(8), .D_WIDTH(8), .STARVE_MAX(SM)) dut (
        .g_clk(g_clk), .g_clr(g_clr),
        .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_gnt(p_gnt), .p_stall(p_stall),
        .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .rvalid(rvalid), .rtag(rtag), .rdata(rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 g_clk = ~g_clk;

    logic [7:0] ram [256];
    logic [7:0] shadow [256];
    int         m_starve;
    bit         m_own_d, m_rvalid, m_rtag;
    logic [7:0] m_rdata;
    int         n_cmp, n_err;
    logic       s_p, s_d, s_rv, s_tag;
    logic [7:0] s_rdata;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit pr, input bit pw, input logic [7:0] pa, input logic [7:0] pd,
                         input bit dr, input bit dw, input bit dl, input logic [7:0] da,
                         input logic [7:0] dd);
        p_req = pr; p_we = pw; p_addr = pa; p_wdata = pd;
        d_req = dr; d_we = dw; d_lock = dl; d_addr = da; d_wdata = dd;
    endtask

    // One clock: predict from the arbitration rules, compare, then advance RAM and model.
    task automatic step(input bit do_chk);
        bit         ed, ep, ewe, ere, rwe, rre;
        logic [7:0] ea, ew, ra, rw;
        #4;
        ed  = d_req && ((m_own_d && d_lock) || m_starve == SM || !p_req);
        ep  = p_req && !ed;
        ewe = (ed && d_we) || (ep && p_we);
        ere = (ed && !d_we) || (ep && !p_we);
        ea  = ed ? d_addr : ep ? p_addr : 8'h00;
        ew  = ed ? d_wdata : ep ? p_wdata : 8'h00;
        s_p = p_gnt; s_d = d_gnt; s_rv = rvalid; s_tag = rtag; s_rdata = rdata;
        rwe = mem_we; rre = mem_re; ra = mem_addr; rw = mem_wdata;
        if (do_chk) begin
            chk("p_gnt", p_gnt, ep);
            chk("d_gnt", d_gnt, ed);
            chk("p_stall", p_stall, p_req && !ep);
            chk("mem_we", mem_we, ewe);
            chk("mem_re", mem_re, ere);
            chk("mem_addr", mem_addr, ea);
            chk("mem_wdata", mem_wdata, ew);
            chk("rvalid", rvalid, m_rvalid);
            chk("rtag", rtag, m_rtag);
            if (m_rvalid) chk("rdata", rdata, m_rdata);
        end
        @(posedge g_clk);
        if (rwe === 1'b1) ram[ra] = rw;
        if (rre === 1'b1) mem_rdata = ram[ra];
        if (ewe) shadow[ea] = ew;
        if (!g_clr) begin
            m_starve = 0; m_own_d = 0; m_rvalid = 0; m_rtag = 0;
        end else begin
            m_starve = (ed || !d_req) ? 0 : (m_starve < SM ? m_starve + 1 : SM);
            m_own_d  = ed;
            m_rvalid = ere;
            m_rtag   = ed;
            if (ere) m_rdata = shadow[ea];
        end
        #1;
    endtask

    initial begin
        int bi, cyc;
        logic [4:0] pat;
        n_cmp = 0; n_err = 0;
        m_starve = 0; m_own_d = 0; m_rvalid = 0; m_rtag = 0; m_rdata = 8'h00;
        for (int i = 0; i < 256; i++) begin
            ram[i] = 8'(i * 37 + 11);
            shadow[i] = ram[i];
        end
        ram[5] = 8'h3C; shadow[5] = 8'h3C;
        mem_rdata = 8'h00;

        // Reset held two cycles with both requesting
        g_clr = 1'b0;
        drive(1, 1, 8'h40, 8'h11, 1, 1, 0, 8'h41, 8'h22);
        step(0);
        step(1);
        chk("rst_rvalid", s_rv, 1'b0);
        g_clr = 1'b1;
        step(1);
        chk("post_rst_p", s_p, 1'b1);
        chk("post_rst_d", s_d, 1'b0);

        // P read of address 5
        drive(1, 0, 8'h05, 8'h00, 0, 0, 0, 8'h00, 8'h00);
        step(1);
        drive(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
        step(1);
        chk("pread_rvalid", s_rv, 1'b1);
        chk("pread_rtag", s_tag, 1'b0);
        chk("pread_rdata", s_rdata, 8'h3C);

        // Starvation: D forced on the fifth consecutive requesting cycle
        pat = '0;
        for (int i = 0; i < 6; i++) begin
            drive(1, 1, 8'h80 + 8'(i), 8'h50 + 8'(i), 1, 0, 0, 8'h90, 8'h00);
            step(1);
            if (i < 5) pat[i] = s_d;
            if (i == 5) chk("starve_p6", s_p, 1'b1);
        end
        chk("starve_pat", 8'(pat), 8'h10);

        // Locked burst writing A0..A2 to 10..12 while P keeps requesting
        bi = 0; cyc = 0;
        while (bi < 3 && cyc < 30) begin
            drive(1, 0, 8'h20, 8'h00, 1, 1, 1, 8'h10 + 8'(bi), 8'hA0 + 8'(bi));
            step(1);
            if (s_d) bi++;
            cyc++;
        end
        chk("burst_grants", 8'(bi), 8'd3);
        drive(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
        step(1);
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 8'h10 + 8'(i), 8'h00, 0, 0, 0, 8'h00, 8'h00);
            step(1);
            drive(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
            step(1);
            chk("burst_rd", s_rdata, 8'hA0 + 8'(i));
        end

        // D read, then clear: read return suppressed and lock abandoned
        drive(0, 0, 8'h00, 8'h00, 1, 0, 1, 8'h33, 8'h00);
        step(1);
        g_clr = 1'b0;
        drive(1, 0, 8'h34, 8'h00, 1, 0, 1, 8'h33, 8'h00);
        step(1);
        g_clr = 1'b1;
        step(1);
        chk("midrst_rvalid", s_rv, 1'b0);
        chk("midrst_p", s_p, 1'b1);

        // Idle
        drive(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
        for (int i = 0; i < 4; i++) step(1);
        chk("idle_mem_addr", mem_addr, 8'h00);

        // Random traffic with occasional clears
        for (int i = 0; i < 500; i++) begin
            g_clr = ($urandom_range(63) != 0);
            drive(1'($urandom_range(1)), 1'($urandom_range(1)), 8'($urandom), 8'($urandom),
                  1'($urandom_range(1)), 1'($urandom_range(1)), ($urandom_range(3) != 0),
                  8'($urandom), 8'($urandom));
            step(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
